// File: rtl/operator_pkg.sv
// Shared opcode and width constants for the operator block.
// Digit format is selected with the OPERATOR_BCD_EN macro.
package operator_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

endpackage

// File: rtl/operator_bin2bcd.sv
// Combinational 5-bit binary to two-digit BCD converter.
// Used by operator only when OPERATOR_BCD_EN is defined.
module operator_bin2bcd
    import operator_pkg::*;
(
    input  logic [RESW-1:0] bin,
    output logic [OPW-1:0]  tens,
    output logic [OPW-1:0]  ones
);

    // Subtract the largest multiple of ten; the low nibble of the
    // remainder equals bin[3:0] minus (10k mod 16), modulo 16.
    always_comb begin
        tens = 4'd0;
        ones = bin[3:0];
        if (bin >= 5'd30) begin
            tens = 4'd3;
            ones = bin[3:0] - 4'd14;
        end else if (bin >= 5'd20) begin
            tens = 4'd2;
            ones = bin[3:0] - 4'd4;
        end else if (bin >= 5'd10) begin
            tens = 4'd1;
            ones = bin[3:0] - 4'd10;
        end
    end

endmodule

// File: rtl/operator.sv
// Registered 4-bit ALU with sign flag and two display digits.
// OPERATOR_BCD_EN selects BCD digits; otherwise hex digits.
module operator
    import operator_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  m,
    input  logic [OPW-1:0]  n,
    input  logic [2:0]      choose,
    output logic [RESW-1:0] f,
    output logic            EN,
    output logic [OPW-1:0]  a,
    output logic [OPW-1:0]  b
);

    logic [RESW-1:0] f_d, f_q;
    logic            en_d, en_q;
    logic [OPW-1:0]  a_d, a_q;
    logic [OPW-1:0]  b_d, b_q;

    // ALU and negative flag; subtract reports magnitude plus sign.
    always_comb begin
        f_d  = '0;
        en_d = 1'b0;
        case (choose)
            OP_ADD: f_d = {1'b0, m} + {1'b0, n};
            OP_SUB: begin
                if (m < n) begin
                    f_d  = {1'b0, n - m};
                    en_d = 1'b1;
                end else begin
                    f_d = {1'b0, m - n};
                end
            end
            OP_AND: f_d = {1'b0, m & n};
            OP_OR:  f_d = {1'b0, m | n};
            OP_XOR: f_d = {1'b0, m ^ n};
            default: f_d = '0;
        endcase
    end

`ifdef OPERATOR_BCD_EN
    operator_bin2bcd u_bin2bcd (
        .bin  (f_d),
        .tens (a_d),
        .ones (b_d)
    );
`else
    // Hex digits taken straight from the unregistered result.
    always_comb begin
        a_d = {3'b000, f_d[4]};
        b_d = f_d[3:0];
    end
`endif

    // All outputs captured together; reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q  <= '0;
            en_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            f_q  <= f_d;
            en_q <= en_d;
            a_q  <= a_d;
            b_q  <= b_d;
        end
    end

    assign f  = f_q;
    assign EN = en_q;
    assign a  = a_q;
    assign b  = b_q;

endmodule

// File: tb/tb_operator.sv
// Self-checking bench for operator against a behavioural model.
// Digit expectations follow the OPERATOR_BCD_EN macro.
module tb_operator;

    logic       clk;
    logic       rst_n;
    logic [3:0] m;
    logic [3:0] n;
    logic [2:0] choose;
    logic [4:0] f;
    logic       EN;
    logic [3:0] a;
    logic [3:0] b;

    int n_chk;
    int n_fail;

    int exp_f, exp_en, exp_a, exp_b;

    operator dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m      (m),
        .n      (n),
        .choose (choose),
        .f      (f),
        .EN     (EN),
        .a      (a),
        .b      (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    task automatic model(input int mm, input int nn, input int ch);
        int d;
        exp_f  = 0;
        exp_en = 0;
        case (ch)
            0: exp_f = mm + nn;
            1: begin
                d = mm - nn;
                if (d < 0) begin
                    exp_f  = -d;
                    exp_en = 1;
                end else begin
                    exp_f = d;
                end
            end
            2: exp_f = mm & nn;
            3: exp_f = mm | nn;
            4: exp_f = mm ^ nn;
            default: exp_f = 0;
        endcase
`ifdef OPERATOR_BCD_EN
        exp_a = exp_f / 10;
        exp_b = exp_f % 10;
`else
        exp_a = exp_f / 16;
        exp_b = exp_f % 16;
`endif
    endtask

    task automatic check_all(input string tag);
        check({tag, ".f"},  int'(f),  exp_f);
        check({tag, ".EN"}, int'(EN), exp_en);
        check({tag, ".a"},  int'(a),  exp_a);
        check({tag, ".b"},  int'(b),  exp_b);
    endtask

    // Drive at negedge, confirm old result still held, then check
    // the new result just after the next rising edge.
    task automatic apply(input string tag, input int mm, input int nn,
                         input int ch);
        @(negedge clk);
        m      = 4'(mm);
        n      = 4'(nn);
        choose = 3'(ch);
        #1;
        check({tag, ".hold"}, int'(f), exp_f);
        @(posedge clk);
        #1;
        model(mm, nn, ch);
        check_all(tag);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        exp_f  = 0;
        exp_en = 0;
        exp_a  = 0;
        exp_b  = 0;
        rst_n  = 1'b0;
        m      = 4'd12;
        n      = 4'd10;
        choose = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model(12, 10, 0);
        check_all("first_edge");

        // Opcode sweep, each held 100 ns.
        for (int ch = 0; ch < 5; ch++) begin
            apply($sformatf("sweep%0d", ch), 12, 10, ch);
            repeat (9) @(posedge clk);
            #1;
            check_all($sformatf("sweep%0d_held", ch));
        end

        apply("neg_sub", 3, 9, 1);
        apply("eq_sub", 7, 7, 1);
        apply("max_add", 15, 15, 0);
        apply("res5", 12, 10, 5);
        apply("res6", 12, 10, 6);
        apply("res7", 12, 10, 7);

        // Choose alone changes the result one edge later.
        apply("ch_only_a", 12, 10, 0);
        apply("ch_only_b", 12, 10, 1);

        // Asynchronous reset pulse between edges.
        apply("pre_rst", 15, 15, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_f  = 0;
        exp_en = 0;
        exp_a  = 0;
        exp_b  = 0;
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model(15, 15, 0);
        check_all("post_rst");

        // Randomized operands and opcodes.
        for (int i = 0; i < 200; i++) begin
            apply("rand", int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operator.md
OPERATOR -- requirements
Module: operator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; both port names follow the codebase convention.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 m  input  4  unsigned operand A.
REQ-005 n  input  4  unsigned operand B.
REQ-006 choose  input  3  operation select.
REQ-007 f  output  5  unsigned result magnitude.
REQ-008 EN  output  1  negative-result flag; 1 = true result is -f.
REQ-009 a  output  4  display high digit.
REQ-010 b  output  4  display low digit.

Function
REQ-011 choose=0 (ADD): f = m+n, zero-extended to 5 bits, max 30; EN=0.
REQ-012 choose=1 (SUB): if m>=n then f=m-n and EN=0; if m<n then f=n-m and EN=1.
REQ-013 choose=2 (AND): f = {1'b0, m&n}; EN=0.
REQ-014 choose=3 (OR): f = {1'b0, m|n}; EN=0.
REQ-015 choose=4 (XOR): f = {1'b0, m^n}; EN=0.
REQ-016 choose=5..7 (reserved): f=0, EN=0, a=0, b=0.
REQ-017 Inputs are sampled every rising clk edge, with no handshake.
REQ-018 f, EN, a and b are registered and SHALL reflect the inputs sampled at the previous edge (1-cycle latency).
REQ-019 All four outputs SHALL update on the same edge.
REQ-020 A change on choose alone SHALL change the outputs one cycle later.
REQ-021 SUB with m==n SHALL give f=0 and EN=0 (no negative zero).
REQ-022 Digit outputs (default build): a = f/10 and b = f%10 (BCD, each 0..9).
  - a <= 3 for every legal f.
  - Derived from the same-cycle f, not from the registered f.

Reset
REQ-023 While rst_n=0, f, EN, a and b SHALL be held at 0, asynchronously.
REQ-024 Assertion mid-operation SHALL clear the outputs immediately, without waiting for clk.
REQ-025 After deassertion, the first rising edge SHALL capture the current inputs; valid outputs follow on that edge.

Configuration
REQ-026 Macro OPERATOR_BCD_EN SHALL control the digit format of a and b.
REQ-027 With OPERATOR_BCD_EN defined: a and b behave as in REQ-022.
REQ-028 Without OPERATOR_BCD_EN: a = {3'b000, f[4]} and b = f[3:0] (hex digits); f and EN are unaffected.

Structure
REQ-029 Package operator_pkg SHALL hold:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4;
  - width constants OPW=4 and RESW=5.
REQ-030 The binary-to-BCD conversion (5-bit in, two 4-bit digits out) SHALL be a combinational sub-module named operator_bin2bcd.
  - It is instantiated only when OPERATOR_BCD_EN is defined.
REQ-031 The ALU and the flag logic SHALL be combinational and reside in operator; the output registers also reside in operator.

Verification
REQ-032 Opcode sweep, m=12, n=10, choose stepping 0..4 each held 100 ns (default build):
  - ADD: f=22, EN=0, a=2, b=2;
  - SUB: f=2, EN=0, a=0, b=2;
  - AND: f=8, a=0, b=8;
  - OR: f=14, a=1, b=4;
  - XOR: f=6, a=0, b=6.
REQ-033 Negative subtract: m=3, n=9, choose=1 -> f=6, EN=1, a=0, b=6; m=n=7 -> f=0, EN=0.
REQ-034 Maximum add: m=15, n=15, choose=0 -> f=30, a=3, b=0 (default build); a=1, b=14 without OPERATOR_BCD_EN.
REQ-035 Reserved opcodes: choose=5, 6, 7 with m=12, n=10 -> f=0, EN=0, a=0, b=0.
REQ-036 Latency and reset:
  - an input change appears on the outputs exactly one edge later;
  - pulsing rst_n low between edges clears all outputs at once;
  - the first edge after release restores the result.
